// File: rtl/conv_result_normalizer.sv
// Sums the nine result words of one convolution window over nine cycles,
// then normalises the sum to a mantissa/exponent pair by leading-one detection.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    window handshake; in_data holds nine PW-bit words
//   out_valid/out_ready  result handshake
//   out_mant, out_exp    normalised mantissa and right-shift amount
//   out_zero, out_sum    zero flag and full-precision sum
module conv_result_normalizer #(
    parameter int N  = 5,
    parameter int PW = 2*N+4,
    parameter int SW = PW+4,
    parameter int OW = 4,
    parameter int EW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [9*PW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_mant,
    output logic [EW-1:0]   out_exp,
    output logic            out_zero,
    output logic [SW-1:0]   out_sum
);

    typedef enum logic [1:0] {IDLE, ACC, NORM, HOLD} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   words [9];
    logic [SW-1:0]   acc;
    logic [3:0]      cnt;
    logic [EW-1:0]   msb;
    logic [EW-1:0]   shift;
    logic [SW-1:0]   shifted;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (in_valid && in_ready) state_n = ACC;
            ACC:  if (cnt == 4'd8) state_n = NORM;
            NORM: state_n = HOLD;
            HOLD: if (out_valid && out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Leading-one position; ascending scan leaves the highest set bit.
    always_comb begin
        msb = '0;
        for (int i = 0; i < SW; i++) begin
            if (acc[i]) msb = EW'(i);
        end
    end

    // Small sums keep their low OW bits unshifted.
    assign shift   = (msb >= EW'(OW-1)) ? msb - EW'(OW-1) : '0;
    assign shifted = acc >> shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_sum   <= '0;
            acc       <= '0;
            cnt       <= '0;
            for (int k = 0; k < 9; k++) words[k] <= '0;
        end else begin
            state    <= state_n;
            // Registered from next state, so never combinational on out_ready.
            in_ready <= (state_n == IDLE);
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < 9; k++)
                            words[k] <= in_data[k*PW +: PW];
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                ACC: begin
                    acc <= acc + {{(SW-PW){1'b0}}, words[cnt]};
                    if (cnt != 4'd8) cnt <= cnt + 4'd1;
                end
                NORM: begin
                    out_sum   <= acc;
                    out_zero  <= (acc == '0);
                    out_mant  <= (acc == '0) ? '0 : shifted[OW-1:0];
                    out_exp   <= (acc == '0) ? '0 : shift;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_result_normalizer.sv
// Bench for conv_result_normalizer: directed windows with literal results
// plus a queue-based sum/normalise model checked every valid cycle.
module tb_conv_result_normalizer;
    localparam int N  = 5;
    localparam int PW = 14;
    localparam int SW = 18;
    localparam int OW = 4;
    localparam int EW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [9*PW-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [OW-1:0]   out_mant;
    logic [EW-1:0]   out_exp;
    logic            out_zero;
    logic [SW-1:0]   out_sum;

    conv_result_normalizer #(.N(N), .PW(PW), .SW(SW), .OW(OW), .EW(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp),
        .out_zero(out_zero), .out_sum(out_sum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        longint sum;
        int     mant;
        int     ex;
        bit     zero;
    } res_t;

    function automatic res_t model(input logic [9*PW-1:0] d);
        res_t   r;
        longint s;
        int     m;
        s = 0;
        m = 0;
        for (int k = 0; k < 9; k++) s += longint'(d[k*PW +: PW]);
        r.sum = s;
        r.zero = (s == 0);
        r.mant = 0;
        r.ex = 0;
        if (s != 0) begin
            while ((s >> (m + 1)) != 0) m++;
            if (m >= OW - 1) begin
                r.ex = m - (OW - 1);
                r.mant = int'((s >> r.ex) % (longint'(1) << OW));
            end else begin
                r.mant = int'(s);
            end
        end
        return r;
    endfunction

    res_t q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(in_data));
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL model_queue actual=empty required=entry");
            end else begin
                chk("model_sum", 64'(out_sum), 64'(q[0].sum));
                chk("model_mant", 64'(out_mant), 64'(q[0].mant));
                chk("model_exp", 64'(out_exp), 64'(q[0].ex));
                chk("model_zero", 64'(out_zero), 64'(q[0].zero));
                chk("model_in_ready_low", 64'(in_ready), 64'd0);
            end
        end
    end

    task automatic run_window(input logic [9*PW-1:0] d, input longint s,
                              input int mant, input int ex, input bit z);
        int n;
        int lat;
        @(negedge clk);
        in_data = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk("latency", 64'(lat), 64'd10);
        chk("sum", 64'(out_sum), 64'(s));
        chk("mant", 64'(out_mant), 64'(mant));
        chk("exp", 64'(out_exp), 64'(ex));
        chk("zero", 64'(out_zero), 64'(z));
        chk("in_ready_in_hold", 64'(in_ready), 64'd0);
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk("in_ready_after_hs", 64'(in_ready), 64'd1);
            chk("valid_after_hs", 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        int lat;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_mant", 64'(out_mant), 64'd0);
        chk("rst_exp", 64'(out_exp), 64'd0);
        chk("rst_zero", 64'(out_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_window({9{14'd1}}, 9, 9, 0, 1'b0);
        run_window({9{14'd100}}, 900, 14, 6, 1'b0);
        run_window({9{14'd16383}}, 147447, 8, 14, 1'b0);
        run_window(126'd5, 5, 5, 0, 1'b0);
        run_window('0, 0, 0, 0, 1'b1);

        // Backpressure: result 63 held while new data streams in.
        out_ready = 1'b0;
        run_window({9{14'd7}}, 63, 15, 2, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_data = {9{14'($urandom_range(0, 16383))}};
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_sum", 64'(out_sum), 64'd63);
            chk("bp_mant", 64'(out_mant), 64'd15);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_data = {9{14'd2}};
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hs_valid", 64'(out_valid), 64'd0);
        chk("bp_hs_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_accept", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp2_latency", 64'(lat), 64'd10);
        chk("bp2_sum", 64'(out_sum), 64'd18);
        chk("bp2_mant", 64'(out_mant), 64'd9);
        chk("bp2_exp", 64'(out_exp), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of accumulation.
        @(negedge clk);
        in_data = {9{14'd50}};
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(out_sum), 64'd0);
        chk("mid_rst_mant", 64'(out_mant), 64'd0);
        chk("mid_rst_exp", 64'(out_exp), 64'd0);
        chk("mid_rst_zero", 64'(out_zero), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_window({9{14'd1}}, 9, 9, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
